// File: rtl/tiny_cpu_pkg.sv
// Shared opcode constants and controller state encoding for tiny_cpu_param.
// The optional multiplier is enabled by defining TINY_CPU_MUL_EN.
package tiny_cpu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'd0;
    localparam logic [OPC_W-1:0] OPC_CLR  = 4'd1;
    localparam logic [OPC_W-1:0] OPC_LDA  = 4'd2;
    localparam logic [OPC_W-1:0] OPC_LDB  = 4'd3;
    localparam logic [OPC_W-1:0] OPC_LDBO = 4'd4;
    localparam logic [OPC_W-1:0] OPC_ADD  = 4'd5;
    localparam logic [OPC_W-1:0] OPC_SHL  = 4'd6;
    localparam logic [OPC_W-1:0] OPC_SHR  = 4'd7;
    localparam logic [OPC_W-1:0] OPC_AND  = 4'd8;
    localparam logic [OPC_W-1:0] OPC_OR   = 4'd9;
    localparam logic [OPC_W-1:0] OPC_XOR  = 4'd10;
    localparam logic [OPC_W-1:0] OPC_NAND = 4'd11;
    localparam logic [OPC_W-1:0] OPC_CMP  = 4'd12;
    localparam logic [OPC_W-1:0] OPC_MUL  = 4'd13;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/tiny_cpu_mul.sv
// Shift-add unsigned multiplier; built only when TINY_CPU_MUL_EN is defined.
// o_done and o_prod are valid combinationally during the WIDTH-th step after i_start.
module tiny_cpu_mul #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_acc_nxt;

    // The final partial sum is exposed before it is registered so the
    // top can capture the product on the same edge the last step happens.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done    = r_busy && (r_cnt == CNT_W'(1));
    assign o_prod    = w_acc_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(WIDTH);
        end else if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/tiny_cpu_param.sv
// Accumulator-style tiny CPU with A/B operand registers and an Out register.
// Define TINY_CPU_MUL_EN to build the multi-cycle MUL opcode; otherwise opcode 13 is illegal.
module tiny_cpu_param
    import tiny_cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Clear,
    input  logic [WIDTH+OPC_W-1:0] In,
    input  logic                   In_valid,
    output logic                   In_ready,
    output logic [WIDTH-1:0]       Result,
    output logic                   Result_valid,
    output logic                   Carry,
    output logic                   Zero,
    output logic                   Illegal
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_zero;
    logic             r_res_vld;
    logic             r_illegal;

    logic [OPC_W-1:0] w_opc;
    logic [WIDTH-1:0] w_data;
    logic             w_acc;
    logic             w_ready;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_c;
    logic             w_alu_op;
    logic             w_illegal;

    assign w_opc  = In[WIDTH+OPC_W-1:WIDTH];
    assign w_data = In[WIDTH-1:0];
    assign w_acc  = In_valid && w_ready;

`ifdef TINY_CPU_MUL_EN
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;

    assign w_illegal = (w_opc == 4'd14) || (w_opc == 4'd15);

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b1;
        w_mul_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (In_valid && (w_opc == OPC_MUL)) begin
                    w_mul_start = 1'b1;
                    w_state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                w_ready = 1'b0;
                if (w_mul_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    tiny_cpu_mul #(.WIDTH(WIDTH)) u_mul (
        .i_clk   (Clk),
        .i_rst   (Clear),
        .i_start (w_mul_start),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_done  (w_mul_done),
        .o_prod  (w_mul_prod)
    );
`else
    assign w_ready   = 1'b1;
    assign w_illegal = (w_opc == OPC_MUL) || (w_opc == 4'd14) || (w_opc == 4'd15);
`endif

    always_comb begin
        w_alu_out = '0;
        w_alu_c   = 1'b0;
        w_alu_op  = 1'b1;
        case (w_opc)
            OPC_ADD:  {w_alu_c, w_alu_out} = {1'b0, r_a} + {1'b0, r_b};
            OPC_SHL: begin
                w_alu_out = {r_a[WIDTH-2:0], 1'b0};
                w_alu_c   = r_a[WIDTH-1];
            end
            OPC_SHR: begin
                w_alu_out = {1'b0, r_a[WIDTH-1:1]};
                w_alu_c   = r_a[0];
            end
            OPC_AND:  w_alu_out = r_a & r_b;
            OPC_OR:   w_alu_out = r_a | r_b;
            OPC_XOR:  w_alu_out = r_a ^ r_b;
            OPC_NAND: w_alu_out = ~(r_a & r_b);
            OPC_CMP:  w_alu_out = (r_a > r_b) ? WIDTH'(1) : '0;
            default:  w_alu_op  = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_a       <= '0;
            r_b       <= '0;
            r_out     <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b1;
            r_res_vld <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_res_vld <= 1'b0;
            r_illegal <= 1'b0;
            if (w_acc) begin
                case (w_opc)
                    OPC_CLR: begin
                        r_a     <= '0;
                        r_b     <= '0;
                        r_out   <= '0;
                        r_carry <= 1'b0;
                        r_zero  <= 1'b0;
                    end
                    OPC_LDA:  r_a <= w_data;
                    OPC_LDB:  r_b <= w_data;
                    OPC_LDBO: r_b <= r_out;
                    default: begin
                        if (w_alu_op) begin
                            r_out     <= w_alu_out;
                            r_carry   <= w_alu_c;
                            r_zero    <= (w_alu_out == '0);
                            r_res_vld <= 1'b1;
                        end else if (w_illegal) begin
                            r_illegal <= 1'b1;
                        end
                    end
                endcase
            end
`ifdef TINY_CPU_MUL_EN
            if (w_mul_done) begin
                r_out     <= w_mul_prod[WIDTH-1:0];
                r_carry   <= |w_mul_prod[2*WIDTH-1:WIDTH];
                r_zero    <= (w_mul_prod[WIDTH-1:0] == '0);
                r_res_vld <= 1'b1;
            end
`endif
        end
    end

    assign In_ready     = w_ready;
    assign Result       = r_out;
    assign Result_valid = r_res_vld;
    assign Carry        = r_carry;
    assign Zero         = r_zero;
    assign Illegal      = r_illegal;

endmodule

// File: tb/tb_tiny_cpu_param.sv
// Directed self-checking bench for tiny_cpu_param (WIDTH=8); MUL scenarios run when TINY_CPU_MUL_EN is defined.
module tb_tiny_cpu_param;

    logic        Clk;
    logic        Clear;
    logic [11:0] In;
    logic        In_valid;
    logic        In_ready;
    logic [7:0]  Result;
    logic        Result_valid;
    logic        Carry;
    logic        Zero;
    logic        Illegal;

    int n_checks = 0;
    int n_fail   = 0;

    tiny_cpu_param #(.WIDTH(8)) dut (
        .Clk          (Clk),
        .Clear        (Clear),
        .In           (In),
        .In_valid     (In_valid),
        .In_ready     (In_ready),
        .Result       (Result),
        .Result_valid (Result_valid),
        .Carry        (Carry),
        .Zero         (Zero),
        .Illegal      (Illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one instruction for a single cycle; returns on the falling edge after acceptance.
    task automatic send(input logic [3:0] op, input logic [7:0] d);
        @(negedge Clk);
        In       = {op, d};
        In_valid = 1'b1;
        @(negedge Clk);
        In_valid = 1'b0;
    endtask

    task automatic test_reset();
        Clear    = 1'b1;
        In       = '0;
        In_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        n_checks++; if (Result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h exp 00", Result); end
        n_checks++; if (Carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b exp 0", Carry); end
        n_checks++; if (Zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b exp 1", Zero); end
        n_checks++; if (Result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %b exp 0", Result_valid); end
        n_checks++; if (Illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b exp 0", Illegal); end
        Clear = 1'b0;
        @(negedge Clk);
        n_checks++; if (In_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", In_ready); end
    endtask

    task automatic test_add();
        send(4'd2, 8'hC8);
        n_checks++; if (Result_valid !== 1'b0) begin n_fail++; $display("FAIL lda_rv got %b exp 0", Result_valid); end
        send(4'd3, 8'h64);
        send(4'd5, 8'h00);
        n_checks++; if (Result_valid !== 1'b1) begin n_fail++; $display("FAIL add_rv got %b exp 1", Result_valid); end
        n_checks++; if (Result !== 8'h2C) begin n_fail++; $display("FAIL add_result got %h exp 2c", Result); end
        n_checks++; if (Carry !== 1'b1) begin n_fail++; $display("FAIL add_carry got %b exp 1", Carry); end
        n_checks++; if (Zero !== 1'b0) begin n_fail++; $display("FAIL add_zero got %b exp 0", Zero); end
        @(negedge Clk);
        n_checks++; if (Result_valid !== 1'b0) begin n_fail++; $display("FAIL add_rv_pulse got %b exp 0", Result_valid); end
    endtask

    task automatic test_shift();
        send(4'd2, 8'h81);
        send(4'd6, 8'h00);
        n_checks++; if (Result !== 8'h02) begin n_fail++; $display("FAIL shl_result got %h exp 02", Result); end
        n_checks++; if (Carry !== 1'b1) begin n_fail++; $display("FAIL shl_carry got %b exp 1", Carry); end
        send(4'd7, 8'h00);
        n_checks++; if (Result !== 8'h40) begin n_fail++; $display("FAIL shr_result got %h exp 40", Result); end
        n_checks++; if (Carry !== 1'b1) begin n_fail++; $display("FAIL shr_carry got %b exp 1", Carry); end
    endtask

    task automatic test_logic();
        send(4'd2, 8'h05);
        send(4'd3, 8'h05);
        send(4'd10, 8'h00);
        n_checks++; if (Result !== 8'h00) begin n_fail++; $display("FAIL xor_result got %h exp 00", Result); end
        n_checks++; if (Zero !== 1'b1) begin n_fail++; $display("FAIL xor_zero got %b exp 1", Zero); end
        n_checks++; if (Carry !== 1'b0) begin n_fail++; $display("FAIL xor_carry got %b exp 0", Carry); end
        send(4'd12, 8'h00);
        n_checks++; if (Result !== 8'h00) begin n_fail++; $display("FAIL cmp_eq got %h exp 00", Result); end
        send(4'd3, 8'h04);
        send(4'd12, 8'h00);
        n_checks++; if (Result !== 8'h01) begin n_fail++; $display("FAIL cmp_gt got %h exp 01", Result); end
        n_checks++; if (Zero !== 1'b0) begin n_fail++; $display("FAIL cmp_gt_zero got %b exp 0", Zero); end
        send(4'd8, 8'h00);
        n_checks++; if (Result !== 8'h04) begin n_fail++; $display("FAIL and_result got %h exp 04", Result); end
        send(4'd9, 8'h00);
        n_checks++; if (Result !== 8'h05) begin n_fail++; $display("FAIL or_result got %h exp 05", Result); end
        send(4'd11, 8'h00);
        n_checks++; if (Result !== 8'hFB) begin n_fail++; $display("FAIL nand_result got %h exp fb", Result); end
    endtask

    task automatic test_ldbo_and_handshake();
        send(4'd2, 8'h03);
        send(4'd3, 8'h04);
        send(4'd5, 8'h00);
        n_checks++; if (Result !== 8'h07) begin n_fail++; $display("FAIL add2_result got %h exp 07", Result); end
        send(4'd4, 8'h00);
        n_checks++; if (Result_valid !== 1'b0) begin n_fail++; $display("FAIL ldbo_rv got %b exp 0", Result_valid); end
        // An instruction presented without In_valid must be ignored.
        @(negedge Clk);
        In = {4'd2, 8'hFF};
        @(negedge Clk);
        send(4'd5, 8'h00);
        n_checks++; if (Result !== 8'h0A) begin n_fail++; $display("FAIL ldbo_add_result got %h exp 0a", Result); end
        n_checks++; if (Carry !== 1'b0) begin n_fail++; $display("FAIL ldbo_add_carry got %b exp 0", Carry); end
    endtask

    task automatic test_illegal();
        send(4'd14, 8'h00);
        n_checks++; if (Illegal !== 1'b1) begin n_fail++; $display("FAIL ill14_pulse got %b exp 1", Illegal); end
        n_checks++; if (Result !== 8'h0A) begin n_fail++; $display("FAIL ill14_result got %h exp 0a", Result); end
        n_checks++; if (Result_valid !== 1'b0) begin n_fail++; $display("FAIL ill14_rv got %b exp 0", Result_valid); end
        @(negedge Clk);
        n_checks++; if (Illegal !== 1'b0) begin n_fail++; $display("FAIL ill14_end got %b exp 0", Illegal); end
        send(4'd15, 8'h00);
        n_checks++; if (Illegal !== 1'b1) begin n_fail++; $display("FAIL ill15_pulse got %b exp 1", Illegal); end
    endtask

    task automatic test_clr();
        send(4'd1, 8'h00);
        n_checks++; if (Result !== 8'h00) begin n_fail++; $display("FAIL clr_result got %h exp 00", Result); end
        n_checks++; if (Carry !== 1'b0) begin n_fail++; $display("FAIL clr_carry got %b exp 0", Carry); end
        n_checks++; if (Result_valid !== 1'b0) begin n_fail++; $display("FAIL clr_rv got %b exp 0", Result_valid); end
        send(4'd5, 8'h00);
        n_checks++; if (Result !== 8'h00) begin n_fail++; $display("FAIL clr_ab_result got %h exp 00", Result); end
        n_checks++; if (Zero !== 1'b1) begin n_fail++; $display("FAIL clr_ab_zero got %b exp 1", Zero); end
    endtask

`ifdef TINY_CPU_MUL_EN
    task automatic test_mul();
        int busy;
        send(4'd2, 8'h10);
        send(4'd3, 8'h11);
        @(negedge Clk);
        In       = {4'd13, 8'h00};
        In_valid = 1'b1;
        @(negedge Clk);
        // Keep a different instruction pending while the multiplier is busy.
        In   = {4'd2, 8'h77};
        busy = 0;
        while (In_ready !== 1'b1 && busy < 20) begin
            busy++;
            n_checks++; if (Result_valid !== 1'b0) begin n_fail++; $display("FAIL mul_busy_rv got %b exp 0", Result_valid); end
            @(negedge Clk);
        end
        n_checks++; if (busy != 8) begin n_fail++; $display("FAIL mul_busy_cycles got %0d exp 8", busy); end
        n_checks++; if (Result_valid !== 1'b1) begin n_fail++; $display("FAIL mul_rv got %b exp 1", Result_valid); end
        n_checks++; if (Result !== 8'h10) begin n_fail++; $display("FAIL mul_result got %h exp 10", Result); end
        n_checks++; if (Carry !== 1'b1) begin n_fail++; $display("FAIL mul_carry got %b exp 1", Carry); end
        @(negedge Clk);
        In_valid = 1'b0;
        send(4'd5, 8'h00);
        n_checks++; if (Result !== 8'h88) begin n_fail++; $display("FAIL mul_held_lda got %h exp 88", Result); end
        send(4'd2, 8'h0F);
        send(4'd3, 8'h0E);
        send(4'd13, 8'h00);
        repeat (8) @(negedge Clk);
        n_checks++; if (Result !== 8'hD2) begin n_fail++; $display("FAIL mul2_result got %h exp d2", Result); end
        n_checks++; if (Carry !== 1'b0) begin n_fail++; $display("FAIL mul2_carry got %b exp 0", Carry); end
    endtask

    task automatic test_mul_abort();
        int pulses;
        send(4'd2, 8'h03);
        send(4'd3, 8'h03);
        send(4'd13, 8'h00);
        repeat (3) @(negedge Clk);
        Clear = 1'b1;
        #1;
        n_checks++; if (Result !== 8'h00) begin n_fail++; $display("FAIL abort_result got %h exp 00", Result); end
        n_checks++; if (Carry !== 1'b0) begin n_fail++; $display("FAIL abort_carry got %b exp 0", Carry); end
        n_checks++; if (Zero !== 1'b1) begin n_fail++; $display("FAIL abort_zero got %b exp 1", Zero); end
        n_checks++; if (In_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b exp 1", In_ready); end
        @(negedge Clk);
        Clear  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (Result_valid === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL abort_rv_pulses got %0d exp 0", pulses); end
        send(4'd14, 8'h00);
        n_checks++; if (Illegal !== 1'b1) begin n_fail++; $display("FAIL abort_illegal got %b exp 1", Illegal); end
        n_checks++; if (Result !== 8'h00) begin n_fail++; $display("FAIL abort_ill_result got %h exp 00", Result); end
    endtask
`else
    task automatic test_mul_disabled();
        send(4'd2, 8'h10);
        send(4'd3, 8'h11);
        send(4'd13, 8'h00);
        n_checks++; if (Illegal !== 1'b1) begin n_fail++; $display("FAIL nomul_illegal got %b exp 1", Illegal); end
        n_checks++; if (Result_valid !== 1'b0) begin n_fail++; $display("FAIL nomul_rv got %b exp 0", Result_valid); end
        n_checks++; if (Result !== 8'h00) begin n_fail++; $display("FAIL nomul_result got %h exp 00", Result); end
        n_checks++; if (In_ready !== 1'b1) begin n_fail++; $display("FAIL nomul_ready got %b exp 1", In_ready); end
        send(4'd5, 8'h00);
        n_checks++; if (Result !== 8'h21) begin n_fail++; $display("FAIL nomul_add got %h exp 21", Result); end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_logic();
        test_ldbo_and_handshake();
        test_illegal();
        test_clr();
`ifdef TINY_CPU_MUL_EN
        test_mul();
        test_mul_abort();
`else
        test_mul_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
